// File: rtl/mo3_serial_scheduler.sv
// Round-robin front end for a shared bit-serial "multiple of 3" residue engine.
// One word is accepted at a time, shifted MSB-first, and the verdict is reported with its owner.
module mo3_serial_scheduler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] data0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         ser_bit,
    output logic         done,
    output logic         is_mult3,
    output logic         owner
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic [1:0]     residue;
    logic [1:0]     residue_next;
    logic           rr;
    logic           cur_owner;
    logic           accept;
    logic           sel;
    logic           last_bit;

    // Handshake: a requester holds req and its word until it sees its gnt pulse,
    // then drops req that same cycle; the engine is out of IDLE long enough for this.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sel        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    sel        = (req0 && req1) ? rr : req1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_bit = (cnt == CW'(1));
    assign busy     = (state != IDLE);
    assign ser_bit  = (state == SHIFT) && shreg[W-1];

    // Residue of the prefix seen so far: r' = (2r + b) mod 3.
    always_comb begin
        residue_next = 2'd0;
        case (residue)
            2'd0:    residue_next = ser_bit ? 2'd1 : 2'd0;
            2'd1:    residue_next = ser_bit ? 2'd0 : 2'd2;
            2'd2:    residue_next = ser_bit ? 2'd2 : 2'd1;
            default: residue_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            cnt       <= '0;
            residue   <= 2'd0;
            rr        <= 1'b0;
            cur_owner <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done      <= 1'b0;
            is_mult3  <= 1'b0;
            owner     <= 1'b0;
        end else begin
            gnt0 <= accept && !sel;
            gnt1 <= accept && sel;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= sel ? data1 : data0;
                        cur_owner <= sel;
                        residue   <= 2'd0;
                        cnt       <= CW'(W);
                    end
                end
                SHIFT: begin
                    residue <= residue_next;
                    shreg   <= {shreg[W-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    // Result registers load on the final shift edge so they are
                    // already stable for the whole REPORT cycle.
                    if (last_bit) begin
                        done     <= 1'b1;
                        is_mult3 <= (residue_next == 2'd0);
                        owner    <= cur_owner;
                    end
                end
                REPORT: begin
                    rr <= !cur_owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
